credit_recv_queue: RTL and testbench
====================================

Name: credit_recv_queue

Overview:
Receiver end of a credit-based link. The sender keeps an up/down credit counter: it decrements on each send and increments on each credit pulse, starting at p_num_entries. This block buffers each arriving message in a circular queue and presents it downstream on a val/rdy interface. It returns one credit pulse per entry freed, so the sender's counter tracks free slots exactly.

Parameters:
p_msg_nbits, 32, message width in bits
p_num_entries, 4, queue depth; equals the sender's initial credit count; must be >= 2 and a power of two
p_count_nbits, 3, width of the occupancy count; must hold the value p_num_entries (clog2(p_num_entries)+1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low; state clears on a rising clk edge while reset==0
send_val  input  1  message arriving from the credit sender; there is no ready signal
send_msg  input  p_msg_nbits  arriving message payload
credit  output  1  one-cycle pulse; each pulse returns exactly one credit to the sender
deq_val  output  1  queue head is valid
deq_rdy  input  1  downstream accepts the head
deq_msg  output  p_msg_nbits  head payload
num_free  output  p_count_nbits  free entries: p_num_entries minus occupancy
overflow  output  1  sticky error flag

Behaviour:
- State:
  - storage array of p_num_entries x p_msg_nbits
  - enq_ptr and deq_ptr, each clog2(p_num_entries) bits; both wrap naturally from p_num_entries-1 to 0
  - count register, p_count_nbits wide
  - credit register, 1 bit
  - overflow register, 1 bit
- Reset (reset==0 at an edge):
  - enq_ptr=0, deq_ptr=0, count=0, credit=0, overflow=0
  - resulting outputs: deq_val=0, num_free=p_num_entries
  - storage contents are don't-care; deq_msg is undefined while deq_val==0
- Reset mid-operation:
  - all buffered entries are discarded
  - no credits are returned for discarded entries; the sender is reset in the same cycle
  - send_val is ignored while reset==0
- Handshake and flags:
  - deq_val = (count != 0)
  - deq_msg = storage[deq_ptr]
  - deq_fire = deq_val && deq_rdy
  - enq_fire = send_val && (count < p_num_entries || deq_fire)
- Enqueue: on enq_fire, write storage[enq_ptr] <= send_msg and advance enq_ptr by 1.
- Latency: a message enqueued at edge N is visible at the head at cycle N+1 at the earliest.
- Dequeue: on deq_fire, advance deq_ptr by 1.
- Count update:
  - count += 1 on enq_fire only
  - count -= 1 on deq_fire only
  - count unchanged when both fire in the same cycle
- Full with simultaneous dequeue:
  - count==p_num_entries, deq_fire and send_val together: the enqueue is accepted into the slot just freed (enq_ptr==deq_ptr)
  - count stays p_num_entries
- Overflow:
  - send_val while count==p_num_entries and !deq_fire is an overflow
  - the message is dropped; pointers and count are unchanged
  - overflow is set to 1 and stays 1 until reset
- Credit return:
  - credit register <= deq_fire, so credit is high exactly the cycle after each dequeue handshake
  - back-to-back dequeues give back-to-back credit pulses
- Occupancy: num_free = p_num_entries - count (combinational).
- Credits in flight: the sum of pulses issued since reset equals the total dequeues; credit is never asserted while reset==0.

Optional Feature:
CREDIT_RECV_QUEUE_BYPASS_EN
- Defined: when count==0 and send_val, deq_val=1 and deq_msg=send_msg in the same cycle (combinational path).
  - If deq_rdy is also high, the message is not written and pointers and count are unchanged.
  - credit still pulses the following cycle.
  - If deq_rdy is low, the message is enqueued normally.
- Undefined: no combinational send-to-deq path; minimum latency is 1 cycle as above.

Test Plan:
- Reset hold: reset=0 for 2 cycles with send_val=1 -> after release deq_val=0, num_free=4, credit=0, overflow=0.
- Fill and drain: send 0xA0..0xA3 on 4 consecutive cycles with deq_rdy=0 -> num_free=0. Then deq_rdy=1 -> deq_msg order A0,A1,A2,A3, 4 credit pulses each one cycle after its handshake, num_free returns to 4.
- Wrap-around: 10 messages 0x00..0x09 with deq_rdy toggling 1,0,1,0 -> output order 0x00..0x09 unchanged across pointer wrap; total credit pulses=10.
- Full plus simultaneous enq/deq: queue full (B0..B3), send_val=1 msg 0xB4 with deq_rdy=1 in the same cycle -> B0 dequeued, B4 accepted, num_free=0, overflow=0, credit next cycle.
- Overflow: queue full, deq_rdy=0, send 0xCC -> overflow=1 sticky, num_free=0. Drain yields 4 original messages, no 0xCC.
- Bypass (macro defined): empty queue, send_val=1 msg 0x55, deq_rdy=1 -> deq_val=1, deq_msg=0x55 same cycle, count stays 0, credit=1 next cycle. Macro undefined: deq_val first rises the next cycle.

Source files
------------

// File: rtl/credit_recv_queue.sv
// Receiver side of a credit link: circular buffer with val/rdy dequeue and one credit pulse per freed entry.
// Optional same-cycle send-to-dequeue path enabled by defining CREDIT_RECV_QUEUE_BYPASS_EN.
module credit_recv_queue #(
  parameter int unsigned p_msg_nbits   = 32,
  parameter int unsigned p_num_entries = 4,
  parameter int unsigned p_count_nbits = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send_val,
  input  logic [p_msg_nbits-1:0]   send_msg,
  output logic                     credit,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [p_msg_nbits-1:0]   deq_msg,
  output logic [p_count_nbits-1:0] num_free,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(p_num_entries);
  localparam logic [p_count_nbits-1:0] FULL = p_count_nbits'(p_num_entries);

  logic [p_msg_nbits-1:0]   mem_q [p_num_entries];
  logic [PTR_W-1:0]         enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]         deq_ptr_q, deq_ptr_d;
  logic [p_count_nbits-1:0] count_q, count_d;
  logic                     credit_q, credit_d;
  logic                     overflow_q, overflow_d;

  logic bypass;
  logic bypass_fire;
  logic deq_fire;
  logic pop;
  logic enq_fire;

`ifdef CREDIT_RECV_QUEUE_BYPASS_EN
  assign bypass = send_val && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign deq_val     = (count_q != '0) || bypass;
  assign deq_msg     = bypass ? send_msg : mem_q[deq_ptr_q];
  assign deq_fire    = deq_val && deq_rdy;
  assign bypass_fire = bypass && deq_rdy;
  // A bypassed message leaves in the same cycle, so it neither occupies a slot nor pops one.
  assign pop         = deq_fire && !bypass_fire;
  assign enq_fire    = send_val && ((count_q < FULL) || deq_fire) && !bypass_fire;
  assign num_free    = FULL - count_q;
  assign credit      = credit_q;
  assign overflow    = overflow_q;

  always_comb begin
    enq_ptr_d  = enq_ptr_q;
    deq_ptr_d  = deq_ptr_q;
    count_d    = count_q;
    credit_d   = deq_fire;
    overflow_d = overflow_q;
    if (enq_fire) enq_ptr_d = enq_ptr_q + PTR_W'(1);
    if (pop)      deq_ptr_d = deq_ptr_q + PTR_W'(1);
    if (enq_fire && !pop)      count_d = count_q + p_count_nbits'(1);
    else if (pop && !enq_fire) count_d = count_q - p_count_nbits'(1);
    if (send_val && (count_q == FULL) && !deq_fire) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enq_ptr_q  <= '0;
      deq_ptr_q  <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      enq_ptr_q  <= enq_ptr_d;
      deq_ptr_q  <= deq_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && enq_fire) mem_q[enq_ptr_q] <= send_msg;
  end

endmodule

// File: tb/tb_credit_recv_queue.sv
// Scoreboard bench for credit_recv_queue; expected messages are queued on send and compared at dequeue.
module tb_credit_recv_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_val;
  logic [31:0] send_msg;
  logic        credit;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_msg;
  logic [2:0]  num_free;
  logic        overflow;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned credit_total = 0;
  logic [31:0] sbq[$];
  logic        m_ovf = 1'b0;

`ifdef CREDIT_RECV_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  credit_recv_queue #(
    .p_msg_nbits(32),
    .p_num_entries(4),
    .p_count_nbits(3)
  ) dut (
    .clk(clk), .reset(reset), .send_val(send_val), .send_msg(send_msg),
    .credit(credit), .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
    .num_free(num_free), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One cycle: entered 1 time unit after a rising edge, left at the same point of the next cycle.
  task automatic drive(input logic sv, input logic [31:0] msg, input logic rdy);
    logic        byp, ev, df, ef, take;
    logic [31:0] head;
    logic [2:0]  exp_nf;
    send_val = sv; send_msg = msg; deq_rdy = rdy;
    #1;
    byp    = BYP && sv && (sbq.size() == 0);
    ev     = (sbq.size() != 0) || byp;
    df     = ev && rdy;
    take   = byp && rdy;
    ef     = sv && ((sbq.size() < 4) || df) && !take;
    exp_nf = 3'(4 - sbq.size());
    checks++;
    if (deq_val !== ev) begin
      errors++; $display("FAIL deq_val: got %b expected %b", deq_val, ev);
    end
    checks++;
    if (num_free !== exp_nf) begin
      errors++; $display("FAIL num_free: got %0d expected %0d", num_free, exp_nf);
    end
    if (ev) begin
      head = byp ? msg : sbq[0];
      checks++;
      if (deq_msg !== head) begin
        errors++; $display("FAIL deq_msg: got %h expected %h", deq_msg, head);
      end
    end
    if (df && !take) void'(sbq.pop_front());
    if (ef) sbq.push_back(msg);
    if (sv && (sbq.size() == 4) && !df && !ef) m_ovf = 1'b1;
    @(posedge clk); #1;
    if (credit === 1'b1) credit_total++;
    checks++;
    if (credit !== df) begin
      errors++; $display("FAIL credit: got %b expected %b", credit, df);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++; $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
    end
  endtask

  task automatic apply_reset(input int unsigned ncyc);
    reset = 1'b0; send_val = 1'b1; send_msg = 32'hDEAD_BEEF; deq_rdy = 1'b1;
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      checks++;
      if (credit !== 1'b0) begin
        errors++; $display("FAIL reset_credit: got %b expected 0", credit);
      end
    end
    reset = 1'b1; send_val = 1'b0; deq_rdy = 1'b0;
    sbq.delete(); m_ovf = 1'b0;
    #1;
    checks++;
    if (deq_val !== 1'b0 || num_free !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got val=%b free=%0d ovf=%b expected val=0 free=4 ovf=0",
               deq_val, num_free, overflow);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int unsigned i = 0; i < 4; i++) drive(1'b1, base + 32'(i), 1'b0);
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    apply_reset(2);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_fill_drain;
    int unsigned c0;
    c0 = credit_total;
    fill(32'hA0);
    drain(4);
    drive(1'b0, '0, 1'b0);
    checks++;
    if (credit_total - c0 != 4) begin
      errors++; $display("FAIL fill_drain_credits: got %0d expected 4", credit_total - c0);
    end
  endtask

  task automatic test_wrap;
    int unsigned c0, sent, cyc;
    logic rdy;
    c0 = credit_total; sent = 0; cyc = 0;
    while (sent < 10 && cyc < 100) begin
      rdy = (cyc % 2) == 0;
      if (sbq.size() < 4 || (rdy && sbq.size() != 0)) begin
        drive(1'b1, 32'(sent), rdy);
        sent++;
      end else begin
        drive(1'b0, '0, rdy);
      end
      cyc++;
    end
    drain(4);
    drive(1'b0, '0, 1'b0);
    checks++;
    if (credit_total - c0 != 10 || sbq.size() != 0) begin
      errors++;
      $display("FAIL wrap_credits: got %0d left=%0d expected 10 left=0", credit_total - c0, sbq.size());
    end
  endtask

  task automatic test_full_simul;
    fill(32'hB0);
    drive(1'b1, 32'hB4, 1'b1);
    drive(1'b0, '0, 1'b0);
    drain(4);
  endtask

  task automatic test_overflow;
    fill(32'hC0);
    drive(1'b1, 32'hCC, 1'b0);
    drive(1'b1, 32'hCD, 1'b0);
    drain(4);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'hD0, 1'b0);
    drive(1'b1, 32'hD1, 1'b0);
    apply_reset(1);
    drive(1'b1, 32'hE0, 1'b0);
    drain(1);
  endtask

  task automatic test_bypass;
    drive(1'b1, 32'h55, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; send_val = 1'b0; send_msg = '0; deq_rdy = 1'b0;
    test_reset;
    test_fill_drain;
    test_wrap;
    test_full_simul;
    test_overflow;
    test_reset_mid;
    test_bypass;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
